// File: rtl/tinyalu_rtl_pkg.sv
// Shared definitions for the tinyalu RTL front-end: op encoding and bus widths.
package tinyalu_rtl_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4
  } alu_op_e;

  // Codes 5..7 have no ALU meaning and are reported back as illegal.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op <= OP_W'(MUL);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Show-ahead synchronous FIFO holding queued ALU commands.
// The head entry is visible on rdata whenever empty is low, so the consumer
// can load it on the same edge that pops it.
module tinyalu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even if the head leaves on the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tinyalu_cmd_issuer.sv
// Command front-end for tinyalu: queues commands, issues them one at a time
// over the start/done handshake, and returns each result with status flags.
module tinyalu_cmd_issuer
  import tinyalu_rtl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_result,
  output logic [2:0]               rsp_op,
  output logic                     rsp_timeout,
  output logic                     rsp_illegal,
  output logic                     alu_start,
  output logic [2:0]               alu_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic                     alu_done,
  input  logic [15:0]              alu_result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int CNT_W   = $clog2(TIMEOUT);
  localparam int ENTRY_W = OP_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_e;

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [OP_W-1:0]     head_op;
  logic [DATA_W-1:0]   head_a;
  logic [DATA_W-1:0]   head_b;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  // The head is consumed only when the FSM is free to start on it.
  assign pop       = (state == IDLE) && !fifo_empty;
  assign {head_op, head_a, head_b} = fifo_rdata;
  assign busy      = (state != IDLE) || !fifo_empty;

  tinyalu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Issue FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            rsp_op <= head_op;
            if (is_legal_op(head_op) && (head_op != OP_W'(NO_OP))) begin
              alu_op    <= head_op;
              alu_a     <= head_a;
              alu_b     <= head_b;
              alu_start <= 1'b1;
              cnt       <= '0;
              state     <= RUN;
            end else begin
              // no_op and illegal codes answer directly without touching the ALU
              rsp_result  <= '0;
              rsp_illegal <= !is_legal_op(head_op);
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end
        end
        RUN: begin
          // done is tested first so it wins over a coincident timeout
          if (alu_done) begin
            rsp_result <= alu_result;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            alu_start   <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_illegal <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Scoreboard bench for tinyalu_cmd_issuer with a behavioural tinyalu responder.
module tb_tinyalu_cmd_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        rsp_illegal;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        busy;
  logic [2:0]  fifo_level;

  tinyalu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 1;          // ALU latency in cycles; 0 means done never comes
  int ready_mode = 0;   // 0 hold low, 1 hold high, 2 random

  logic [20:0] exp_q[$];   // {result, op, timeout, illegal}
  int          pulse_q[$]; // expected alu_start high time per issued command

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a response must contain, from op, operands and ALU latency.
  function automatic logic [20:0] ref_rsp(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input int l);
    int r = 0;
    logic to = 1'b0;
    logic il = 1'b0;
    if (op > 3'd4) il = 1'b1;
    else if (op != 3'd0) begin
      if (l == 0 || l > TIMEOUT) to = 1'b1;
      else begin
        case (op)
          3'd1: r = int'(a) + int'(b);
          3'd2: r = int'(a & b);
          3'd3: r = int'(a ^ b);
          default: r = int'(a) * int'(b);
        endcase
      end
    end
    return {r[15:0], op, to, il};
  endfunction

  function automatic int ref_len(input int l);
    return (l >= 1 && l <= TIMEOUT) ? l : TIMEOUT;
  endfunction

  // tinyalu responder: raises done on the lat-th cycle of start, checks operand hold
  logic [18:0] held;
  int cyc = 0;
  always @(negedge clk) begin
    if (reset || !alu_start) begin
      cyc = 0;
      alu_done = 1'b0;
      alu_result = 16'($urandom);
    end else begin
      cyc++;
      if (cyc == 1) held = {alu_op, alu_a, alu_b};
      else check("alu_hold", {13'd0, alu_op, alu_a, alu_b}, {13'd0, held});
      if (lat != 0 && cyc == lat) begin
        alu_done = 1'b1;
        case (alu_op)
          3'd1: alu_result = {8'd0, alu_a} + {8'd0, alu_b};
          3'd2: alu_result = {8'd0, alu_a & alu_b};
          3'd3: alu_result = {8'd0, alu_a ^ alu_b};
          3'd4: alu_result = alu_a * alu_b;
          default: alu_result = 16'hDEAD;
        endcase
      end else begin
        alu_done = 1'b0;
        alu_result = 16'($urandom);
      end
    end
  end

  // alu_start pulse monitor: pulse length and minimum low gap
  bit prev_hi = 0;
  int hi_len = 0;
  int low_len = 100;
  always @(negedge clk) begin
    if (reset) begin
      prev_hi = 0; hi_len = 0; low_len = 100;
    end else if (alu_start) begin
      if (!prev_hi) check("start_gap", {31'd0, low_len >= 2}, 32'd1);
      prev_hi = 1;
      hi_len++;
    end else begin
      if (prev_hi) begin
        if (pulse_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_pulse: got unexpected pulse of %0d cycles expected none", hi_len);
        end else check("start_len", hi_len, pulse_q.pop_front());
        hi_len = 0; low_len = 0;
      end
      prev_hi = 0;
      low_len++;
    end
  end

  // Response monitor: compare at each handshake, and hold while stalled
  logic [20:0] last_rsp;
  bit stalled = 0;
  always @(negedge clk) begin
    if (reset) stalled = 0;
    else if (rsp_valid) begin
      if (stalled) check("rsp_hold", {11'd0, rsp_result, rsp_op, rsp_timeout, rsp_illegal}, {11'd0, last_rsp});
      last_rsp = {rsp_result, rsp_op, rsp_timeout, rsp_illegal};
      if (rsp_ready) begin
        stalled = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp: got unexpected response %h expected none", last_rsp);
        end else check("rsp", {11'd0, last_rsp}, {11'd0, exp_q.pop_front()});
      end else stalled = 1;
    end else stalled = 0;
  end

  // rsp_ready driver; changes only just after a rising edge
  always @(posedge clk) begin
    #1;
    rsp_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom) : 1'b0;
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bit ok = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = cmd_ready;
      if (ok) begin
        exp_q.push_back(ref_rsp(op, a, b, lat));
        if (op >= 3'd1 && op <= 3'd4) pulse_q.push_back(ref_len(lat));
      end
      @(posedge clk);
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send: got no cmd_ready expected acceptance op=%0d", op);
    end
    #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 3000);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle: got busy=%0d pending=%0d expected drained", busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu", {12'd0, alu_start, alu_op, alu_a, alu_b}, 32'd0);
    check("rst_rsp", {11'd0, rsp_result, rsp_op, rsp_timeout, rsp_illegal}, 32'd0);
    check("rst_busy_level", {28'd0, busy, fifo_level}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // add: latency from handshake to start and from done to response
    ready_mode = 1; lat = 1;
    repeat (2) @(posedge clk); #1;
    send(3'd1, 8'h10, 8'h20);
    @(negedge clk) check("lat_pre_start", {31'd0, alu_start}, 32'd0);
    @(negedge clk) check("lat_start", {31'd0, alu_start}, 32'd1);
    @(negedge clk) check("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // mul with 3-cycle ALU
    lat = 3;
    send(3'd4, 8'hFF, 8'hFF);
    wait_idle();

    // backpressure: 5 accepted, then full
    ready_mode = 0; lat = 2;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(3'(1 + (i % 4)), 8'(i * 17 + 3), 8'(i * 29 + 5));
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h55; cmd_b = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
      check("bp_level", {29'd0, fifo_level}, 32'd4);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    ready_mode = 1;
    send(3'd1, 8'h55, 8'hAA);
    send(3'd3, 8'hC3, 8'h3C);
    wait_idle();

    // no_op and illegal never raise alu_start
    send(3'd0, 8'h12, 8'h34);
    send(3'd6, 8'h56, 8'h78);
    wait_idle();

    // timeout, then a normal add
    lat = 0;
    send(3'd2, 8'hF0, 8'h3C);
    wait_idle();
    lat = 1;
    send(3'd1, 8'h01, 8'h02);
    wait_idle();

    // reset in the middle of a mul with 3 queued behind it
    ready_mode = 0; lat = 0;
    repeat (2) @(posedge clk); #1;
    send(3'd4, 8'h0F, 8'h0F);
    for (int i = 0; i < 3; i++) send(3'd1, 8'(i), 8'(i));
    #1 reset = 1'b1;
    #1;
    check("mid_rst_start", {31'd0, alu_start}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    pulse_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ready_mode = 1; lat = 1;
    repeat (20) @(posedge clk);
    @(negedge clk) check("post_rst_quiet", {30'd0, rsp_valid, busy}, 32'd0);
    @(posedge clk); #1;
    send(3'd3, 8'hAA, 8'h0F);
    wait_idle();

    // randomized batches across latencies, including the done-vs-timeout tie
    for (int bt = 0; bt < 6; bt++) begin
      case (bt)
        0: lat = 16;
        1: lat = 17;
        2: lat = 0;
        3: lat = 1;
        default: lat = $urandom_range(1, 8);
      endcase
      ready_mode = 2;
      for (int i = 0; i < 12; i++)
        send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      wait_idle();
    end

    check("end_pulses_drained", pulse_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tinyalu_cmd_issuer.md
Name: tinyalu_cmd_issuer

Overview:
- RTL front-end that sits directly upstream of the tinyalu DUT and drives its start/op/A/B/done protocol.
- Accepts ALU commands on a valid/ready port and buffers them in a small FIFO.
- Issues the commands to tinyalu one at a time, then returns each result (with status) on a valid/ready response port.
- Replaces the behavioural driver for synthesizable, FPGA-resident stimulus.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2).
- TIMEOUT, 16, max cycles alu_start is held without alu_done before abort (≥4).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both are high.
- cmd_op  in  3  0 no_op, 1 add, 2 and, 3 xor, 4 mul, 5–7 illegal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both are high.
- rsp_result  out  16  ALU result.
- rsp_op  out  3  echo of the command op.
- rsp_timeout  out  1  ALU did not assert done within TIMEOUT.
- rsp_illegal  out  1  op was 5–7; not issued to the ALU.
- alu_start  out  1  to tinyalu start.
- alu_op  out  3  to tinyalu op.
- alu_a  out  8  to tinyalu A.
- alu_b  out  8  to tinyalu B.
- alu_done  in  1  from tinyalu done.
- alu_result  in  16  from tinyalu result.
- busy  out  1  FSM not IDLE or FIFO not empty.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, immediate):
  - FIFO emptied, fifo_level=0, cmd_ready=1.
  - FSM=IDLE, all alu_* outputs 0.
  - rsp_valid=0, rsp_result/rsp_op/rsp_timeout/rsp_illegal=0, busy=0.
- Reset mid-operation drops the in-flight and queued commands with no response; alu_start falls immediately.
- FIFO:
  - Push on cmd_valid&&cmd_ready; cmd_ready = !full.
  - Full blocks a push even when a pop happens in the same cycle.
  - Pop only in IDLE when not empty; pointers wrap modulo DEPTH.
- FSM states IDLE, RUN, RESP:
  - IDLE, FIFO non-empty at an edge: pop the head into op/a/b registers.
    - op 1–4: drive alu_op/a/b, alu_start<=1, cycle counter<=0, go RUN.
    - op 0: go RESP with result 0. alu_start is never raised.
    - op 5–7: go RESP with result 0 and rsp_illegal=1. alu_start is never raised.
  - RUN, alu_done=1 at an edge: capture alu_result, alu_start<=0, go RESP.
  - RUN, no done: counter increments each cycle. At counter==TIMEOUT-1: alu_start<=0, result 0, rsp_timeout=1, go RESP.
  - RUN, done on the same edge as the timeout limit: done wins (valid result, rsp_timeout=0).
  - RESP: rsp_valid=1, outputs stable until rsp_ready. On the handshake edge: rsp_valid<=0, flags cleared, go IDLE.
- Latency, with the FIFO empty and the FSM idle:
  - Command handshake at edge N: alu_start high after edge N+1.
  - Done sampled at edge M: rsp_valid high after edge M.
- Spacing: alu_op/a/b stay held while alu_start=1. alu_start is low for ≥2 cycles between commands (RESP + IDLE), which satisfies tinyalu's start-low requirement.
- Widths: counter is $clog2(TIMEOUT) bits, no wrap (the abort resets it). Results pass through unmodified.
- busy is combinational.

Decomposition:
- Shared package tinyalu_rtl_pkg:
  - op encoding enum (NO_OP, ADD, AND, XOR, MUL).
  - OP_W=3, DATA_W=8, RES_W=16.
  - is_legal_op function.
- Sub-module tinyalu_cmd_fifo: parameterised sync FIFO (DEPTH, width = OP_W+2*DATA_W) with async active-high reset, providing full/empty/level.
- FSM and response registers stay in tinyalu_cmd_issuer.

Test Plan:
- Add: op=1, A=8'h10, B=8'h20, rsp_ready=1, model asserts done 1 cycle after start → rsp_result=16'h0030, rsp_op=1, flags 0; alu_start high exactly 1 cycle, asserted 1 edge after cmd handshake.
- Mul: op=4, A=8'hFF, B=8'hFF, model done after 3 cycles → rsp_result=16'hFE01; alu_start high 3 cycles; alu_a/alu_b stable throughout.
- Backpressure, DEPTH=4, rsp_ready=0, 7 commands offered back-to-back:
  - 5 accepted (1 in FSM, 4 in FIFO), then cmd_ready=0 and fifo_level=4.
  - Releasing rsp_ready returns 5 responses in order.
  - alu_start low ≥2 cycles between commands.
- No_op / illegal: op=0 → rsp_result=0, rsp_illegal=0, alu_start never asserted. op=6 → rsp_illegal=1, alu_start never asserted.
- Timeout: alu_done tied 0, op=2 → alu_start high 16 cycles, then rsp_valid with rsp_timeout=1, rsp_result=0. A following add completes normally.
- Reset mid-op: reset asserted 2 cycles into a mul with 3 queued → alu_start, rsp_valid, busy drop immediately, fifo_level=0, cmd_ready=1; no response emitted after release.
